// File: rtl/vga_pkg.sv
// Shared types and timing constants for the VGA pixel fetch path.
package vga_pkg;
  localparam int HFP    = 40;
  localparam int HPULSE = 48;
  localparam int HBP    = 88;
  localparam int VFP    = 13;
  localparam int VPULSE = 3;
  localparam int VBP    = 32;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DONE
  } fetch_state_t;
endpackage

// File: rtl/vga_pix_fifo.sv
// Synchronous pixel FIFO with flush; head word visible on rd_data.
module vga_pix_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          pixel_clk,
  input  logic          pixel_rst,
  input  logic          flush,
  input  logic          wr_en,
  input  rgb_t          wr_data,
  input  logic          rd_en,
  output rgb_t          rd_data,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);
  rgb_t mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic do_wr;
  logic do_rd;

  assign full  = level == LW'(DEPTH);
  assign empty = level == '0;
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign rd_data = mem[rp];

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (do_wr) wp <= wp + AW'(1);
      if (do_rd) rp <= rp + AW'(1);
      level <= level + LW'(do_wr) - LW'(do_rd);
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (do_wr && !flush) mem[wp] <= wr_data;
  end
endmodule

// File: rtl/vga_fetch_ctrl.sv
// Framebuffer read-burst controller feeding a pixel FIFO.
module vga_fetch_ctrl
  import vga_pkg::*;
#(
  parameter int          HDISP      = 800,
  parameter int          VDISP      = 480,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 256,
  parameter int          BURST      = 16
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic        frame_start,
  input  logic        pix_req,
  output logic [23:0] pix_rgb,
  output logic        pix_valid,
  output logic        underflow,
  output logic        mem_stb,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_dat
);
  localparam int TOTAL = HDISP * VDISP;
  localparam int CW = $clog2(TOTAL + 1);
  localparam int BW = $clog2(BURST + 1);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t state;
  fetch_state_t state_nx;
  logic [31:0]   addr;
  logic [CW-1:0] count;
  logic [BW-1:0] bcnt;
  logic [LW-1:0] level;
  logic full;
  logic empty;
  logic acc;
  logic last_word;
  logic burst_end;
  logic room;
  rgb_t head;
  rgb_t wdat;
  logic unused_bits;

  assign mem_stb   = state == FETCH;
  assign mem_addr  = addr;
  assign acc       = mem_stb && mem_ack &&
                     !frame_start && !full;
  assign last_word = count == CW'(TOTAL - 1);
  assign burst_end = bcnt == BW'(BURST - 1);
  assign room      = int'(level) + BURST <= FIFO_DEPTH;
  assign wdat      = rgb_t'(mem_dat[23:0]);
  assign unused_bits = ^mem_dat[31:24];

  vga_pix_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .pixel_clk (pixel_clk),
    .pixel_rst (pixel_rst),
    .flush     (frame_start),
    .wr_en     (acc),
    .wr_data   (wdat),
    .rd_en     (pix_req),
    .rd_data   (head),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) state <= IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (frame_start) begin
      state_nx = FETCH;
    end else begin
      unique case (state)
        IDLE: ;
        FETCH: begin
          // end of frame wins over end of burst
          if (acc && last_word)      state_nx = DONE;
          else if (acc && burst_end) state_nx = HOLD;
        end
        HOLD:    if (room) state_nx = FETCH;
        DONE: ;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      addr  <= BASE_ADDR;
      count <= '0;
      bcnt  <= '0;
    end else if (frame_start) begin
      addr  <= BASE_ADDR;
      count <= '0;
      bcnt  <= '0;
    end else if (acc) begin
      addr  <= addr + 32'd4;
      count <= count + CW'(1);
      bcnt  <= burst_end ? '0 : bcnt + BW'(1);
    end
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      pix_rgb   <= '0;
      pix_valid <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pix_valid <= 1'b0;
      if (pix_req) begin
        if (!empty) begin
          pix_rgb   <= head;
          pix_valid <= 1'b1;
        end else begin
          pix_rgb   <= '0;
          underflow <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_vga_fetch_ctrl.sv
// Randomized and directed checks of vga_fetch_ctrl against a queue model.
module tb_vga_fetch_ctrl;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic pixel_clk = 0;
  logic pixel_rst = 0;
  logic frame_start = 0;
  logic pix_req = 0;
  logic mem_ack = 0;
  logic [31:0] mem_dat = 0;
  logic [23:0] pix_rgb;
  logic pix_valid, underflow, mem_stb;
  logic [31:0] mem_addr;

  logic fs_s = 0;
  logic req_s = 0;
  logic ack_s = 0;
  logic [31:0] dat_s = 0;
  logic [23:0] rgb_s;
  logic valid_s, uf_s, stb_s;
  logic [31:0] addr_s;

  int total = 0;
  int bad = 0;
  logic [23:0] q[$];
  int n = 0;
  logic [23:0] exp_rgb = 0;
  logic m_uf = 0;

  always #5 pixel_clk = ~pixel_clk;

  vga_fetch_ctrl #(.BASE_ADDR(BASE)) dut (
    .pixel_clk(pixel_clk), .pixel_rst(pixel_rst),
    .frame_start(frame_start), .pix_req(pix_req),
    .pix_rgb(pix_rgb), .pix_valid(pix_valid),
    .underflow(underflow), .mem_stb(mem_stb),
    .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_dat(mem_dat)
  );

  vga_fetch_ctrl #(.HDISP(8), .VDISP(2)) dut_s (
    .pixel_clk(pixel_clk), .pixel_rst(pixel_rst),
    .frame_start(fs_s), .pix_req(req_s),
    .pix_rgb(rgb_s), .pix_valid(valid_s),
    .underflow(uf_s), .mem_stb(stb_s),
    .mem_addr(addr_s), .mem_ack(ack_s),
    .mem_dat(dat_s)
  );

  task automatic step(input logic fs, input logic req,
                      input logic ack);
    logic stb0;
    logic [31:0] a0;
    logic ev;
    frame_start = fs;
    pix_req = req;
    mem_ack = ack;
    mem_dat = $urandom;
    stb0 = mem_stb;
    a0 = mem_addr;
    @(posedge pixel_clk); #1;
    ev = 0;
    if (req) begin
      if (q.size() > 0) begin
        exp_rgb = q.pop_front();
        ev = 1;
      end else begin
        exp_rgb = 0;
        m_uf = 1;
      end
    end
    if (fs) begin
      q.delete();
      n = 0;
    end else if (stb0 && ack) begin
      total++;
      if (a0 !== BASE + 32'(4 * n)) begin
        bad++;
        $display("FAIL addr: got %h want %h", a0, BASE + 32'(4 * n));
      end
      q.push_back(mem_dat[23:0]);
      n++;
    end
    total++;
    if ({pix_valid, pix_rgb, underflow} !== {ev, exp_rgb, m_uf}) begin
      bad++;
      $display("FAIL pixel: got v=%b rgb=%h uf=%b want v=%b rgb=%h uf=%b",
               pix_valid, pix_rgb, underflow, ev, exp_rgb, m_uf);
    end
    total++;
    if (q.size() > 256) begin
      bad++;
      $display("FAIL overflow: got level %0d want <=256", q.size());
    end
  endtask

  task automatic model_reset();
    q.delete();
    n = 0;
    exp_rgb = 0;
    m_uf = 0;
  endtask

  task automatic test_reset();
    frame_start = 0; pix_req = 0; mem_ack = 0;
    #2 pixel_rst = 1;
    repeat (2) @(posedge pixel_clk);
    #1;
    total++;
    if ({mem_stb, mem_addr, pix_rgb, pix_valid, underflow, stb_s} !==
        {1'b0, BASE, 24'h0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset: got stb=%b addr=%h rgb=%h v=%b uf=%b",
               mem_stb, mem_addr, pix_rgb, pix_valid, underflow);
    end
    pixel_rst = 0;
    model_reset();
    @(posedge pixel_clk); #1;
  endtask

  task automatic test_fill();
    step(1, 0, 1);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (mem_stb !== 1'b1 || mem_addr !== BASE + 32'(4 * i)) begin
        bad++;
        $display("FAIL burst%0d: got stb=%b addr=%h want 1 %h",
                 i, mem_stb, mem_addr, BASE + 32'(4 * i));
      end
      step(0, 0, 1);
    end
    total++;
    if (mem_stb !== 1'b0) begin
      bad++;
      $display("FAIL hold: got stb=%b want 0", mem_stb);
    end
    repeat (300) step(0, 0, 1);
    total++;
    if (n !== 256 || mem_stb !== 1'b0) begin
      bad++;
      $display("FAIL fill: got words=%0d stb=%b want 256 0", n, mem_stb);
    end
  endtask

  task automatic test_drain();
    repeat (256) step(0, 1, 0);
    step(0, 1, 0);
    total++;
    if (underflow !== 1'b1 || pix_valid !== 1'b0) begin
      bad++;
      $display("FAIL underflow: got uf=%b v=%b want 1 0", underflow, pix_valid);
    end
  endtask

  task automatic test_stall();
    logic [31:0] a0;
    total++;
    if (mem_stb !== 1'b1) begin
      bad++;
      $display("FAIL refetch: got stb=%b want 1", mem_stb);
    end
    a0 = mem_addr;
    repeat (5) begin
      step(0, 0, 0);
      total++;
      if (mem_stb !== 1'b1 || mem_addr !== a0) begin
        bad++;
        $display("FAIL stall: got stb=%b addr=%h want 1 %h", mem_stb, mem_addr, a0);
      end
    end
    step(0, 0, 1);
    total++;
    if (mem_addr !== a0 + 32'd4) begin
      bad++;
      $display("FAIL stall_ack: got %h want %h", mem_addr, a0 + 32'd4);
    end
    step(0, 1, 0);
    step(0, 1, 0);
    total++;
    if (pix_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_write: got v=%b want 0", pix_valid);
    end
  endtask

  task automatic test_restart();
    step(1, 0, 0);
    for (int c = 0; c < 300 && q.size() != 100; c++) step(0, 0, 1);
    total++;
    if (q.size() != 100 || mem_stb !== 1'b1) begin
      bad++;
      $display("FAIL level100: got %0d stb=%b want 100 1", q.size(), mem_stb);
    end
    step(1, 0, 1);
    total++;
    if (mem_stb !== 1'b1 || mem_addr !== BASE) begin
      bad++;
      $display("FAIL restart: got stb=%b addr=%h want 1 %h", mem_stb, mem_addr, BASE);
    end
    step(0, 1, 0);
    total++;
    if (pix_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush: got v=%b want 0", pix_valid);
    end
    step(0, 0, 1);
  endtask

  task automatic test_random();
    step(1, 0, 0);
    repeat (1500)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
           1'($urandom_range(0, 1)));
    repeat (1500)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0,
           1'($urandom_range(0, 1)));
  endtask

  task automatic test_reset_mid();
    step(1, 0, 0);
    step(0, 0, 1);
    total++;
    if (mem_stb !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset: got stb=%b want 1", mem_stb);
    end
    mem_ack = 1;
    #2 pixel_rst = 1;
    #1;
    total++;
    if ({mem_stb, mem_addr, pix_rgb, pix_valid, underflow} !==
        {1'b0, BASE, 24'h0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL async_reset: got stb=%b addr=%h rgb=%h v=%b uf=%b",
               mem_stb, mem_addr, pix_rgb, pix_valid, underflow);
    end
    repeat (2) @(posedge pixel_clk);
    #1 pixel_rst = 0;
    model_reset();
    repeat (5) begin
      @(posedge pixel_clk); #1;
      total++;
      if (mem_stb !== 1'b0 || mem_addr !== BASE) begin
        bad++;
        $display("FAIL post_reset: got stb=%b addr=%h want 0 %h", mem_stb, mem_addr, BASE);
      end
    end
    mem_ack = 0;
  endtask

  task automatic test_small();
    int k;
    fs_s = 1;
    @(posedge pixel_clk); #1;
    fs_s = 0;
    ack_s = 1;
    k = 0;
    for (int c = 0; c < 60; c++) begin
      if (stb_s) begin
        total++;
        if (addr_s !== 32'(4 * k)) begin
          bad++;
          $display("FAIL small_addr: got %h want %h", addr_s, 32'(4 * k));
        end
        dat_s = 32'(k);
        @(posedge pixel_clk); #1;
        k++;
      end else begin
        @(posedge pixel_clk); #1;
      end
    end
    ack_s = 0;
    total++;
    if (k !== 16 || stb_s !== 1'b0) begin
      bad++;
      $display("FAIL small_done: got words=%0d stb=%b want 16 0", k, stb_s);
    end
    for (int i = 0; i < 16; i++) begin
      req_s = 1;
      @(posedge pixel_clk); #1;
      total++;
      if (rgb_s !== 24'(i) || valid_s !== 1'b1) begin
        bad++;
        $display("FAIL small_pix%0d: got %h v=%b want %h 1", i, rgb_s, valid_s, 24'(i));
      end
    end
    req_s = 0;
    @(posedge pixel_clk); #1;
    total++;
    if (valid_s !== 1'b0 || rgb_s !== 24'd15 || uf_s !== 1'b0) begin
      bad++;
      $display("FAIL small_idle: got v=%b rgb=%h uf=%b want 0 f 0", valid_s, rgb_s, uf_s);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_stall();
    test_restart();
    test_random();
    test_reset_mid();
    test_small();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule

// File: doc/vga_fetch_ctrl.md
VGA_FETCH_CTRL -- requirements
Module: vga_fetch_ctrl

Interface
REQ-001 Parameter HDISP, default 800, active pixels per line.
REQ-002 Parameter VDISP, default 480, active lines per frame.
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000, byte address of framebuffer pixel (0,0).
REQ-004 Parameter FIFO_DEPTH, default 256, pixel FIFO entries (power of two, >= 2*BURST).
REQ-005 Parameter BURST, default 16, words per fetch burst.
REQ-006 Clock pixel_clk; reset pixel_rst, asynchronous, active-high.
REQ-007 pixel_clk  in  1  pixel clock, all logic in this domain.
REQ-008 pixel_rst  in  1  asynchronous active-high reset.
REQ-009 frame_start  in  1  one-cycle pulse at start of vertical blanking.
REQ-010 pix_req  in  1  display consumes one pixel this cycle (active region).
REQ-011 pix_rgb  out  24  pixel {R,G,B}, registered.
REQ-012 pix_valid  out  1  pix_rgb holds FIFO data (not underflow filler).
REQ-013 underflow  out  1  sticky: pix_req seen with FIFO empty.
REQ-014 mem_stb  out  1  read request strobe.
REQ-015 mem_addr  out  32  word-aligned byte address of request.
REQ-016 mem_ack  in  1  request accepted, mem_dat valid same cycle.
REQ-017 mem_dat  in  32  read data, pixel in bits [23:0].

Function
REQ-018 FSM states IDLE, FETCH, HOLD, DONE.
REQ-019 IDLE: mem_stb=0; on frame_start -> FETCH, addr=BASE_ADDR, fetched count=0.
REQ-020 FETCH: mem_stb=1 with mem_addr; each cycle mem_stb&&mem_ack writes mem_dat[23:0] to FIFO, addr+=4, count+=1.
REQ-021 mem_addr and mem_stb shall stay stable while mem_stb=1 and mem_ack=0.
REQ-022 FETCH -> HOLD after BURST acks in current burst; FETCH -> DONE when count reaches HDISP*VDISP (takes precedence).
REQ-023 HOLD: mem_stb=0; -> FETCH when FIFO free space >= BURST.
REQ-024 DONE: mem_stb=0 until frame_start.
REQ-025 frame_start in any state: flush FIFO, addr=BASE_ADDR, count=0, -> FETCH next cycle; an ack coinciding with frame_start is discarded.
REQ-026 FIFO shall never be written when full; BURST gating guarantees this.
REQ-027 pix_req with FIFO non-empty: pop, pix_rgb=head data, pix_valid=1 next cycle (latency 1).
REQ-028 pix_req with FIFO empty: pix_rgb=24'h000000, pix_valid=0 next cycle, underflow set.
REQ-029 No pix_req: pix_rgb holds, pix_valid=0.
REQ-030 Simultaneous FIFO write and read shall both occur; level unchanged.
REQ-031 Count width $clog2(HDISP*VDISP+1); address wraps modulo 2^32.

Reset
REQ-032 Reset: state IDLE, mem_stb=0, mem_addr=BASE_ADDR, FIFO empty, pix_rgb=0, pix_valid=0, underflow=0.
REQ-033 Reset mid-burst: mem_stb drops asynchronously; outstanding ack after release ignored (state IDLE).
REQ-034 underflow cleared only by reset.

Structure
REQ-035 Package vga_pkg holds timing constants (HFP, HPULSE, HBP, VFP, VPULSE, VBP), rgb_t (24-bit packed struct r,g,b) and fetch_state_t enum.
REQ-036 Sub-module vga_pix_fifo: synchronous FIFO, parameter DEPTH, width 24, outputs level, full, empty; same clock/reset.

Verification
REQ-037 Reset, frame_start, mem_ack always 1: addresses BASE, BASE+4, ... BASE+60, then HOLD; with no pix_req FIFO fills to 256 and stalls.
REQ-038 HDISP=8, VDISP=2, mem_dat=index: 16 words fetched then DONE; 16 pix_req yield pix_rgb 0..15, pix_valid=1, underflow=0.
REQ-039 pix_req asserted before first ack: pix_rgb=0, pix_valid=0, underflow=1 and stays 1 through later frames.
REQ-040 mem_ack held low 5 cycles: mem_addr/mem_stb stable, no FIFO write, then single write on ack.
REQ-041 frame_start mid-frame with FIFO at 100 entries: FIFO empty next cycle, next mem_addr=BASE_ADDR, coincident ack discarded.
REQ-042 pixel_rst asserted during FETCH: mem_stb=0 immediately, all outputs at reset values, IDLE after release.
